// File: rtl/mult_seq_if.sv
// mult_seq_if: handshake and data bundle for the sequential multiplier.
//   in_valid/in_ready   : operand handshake, a/b carry the operand pair
//   out_valid/out_ready : result handshake, p carries the 2*WIDTH product
//   op_count            : count of completed products, wraps at 256
// The slave modport is the multiplier's view; master is the producer/consumer view.
interface mult_seq_if #(
    parameter int WIDTH = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic [7:0]           op_count;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, op_count
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, op_count
    );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: shift-add multiplier, one multiplier bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : mult_seq_if slave modport (operand handshake, result handshake,
//          product p and wrapping op_count)
// Parameters: WIDTH operand width (2..32), SIGNED 0 = unsigned, 1 = two's complement.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// RUN   | one shift-add step per edge, WIDTH steps total
// DONE  | out_valid=1, p held until out_ready
module mult_seq #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic      clk,
    input  logic      rst,
    mult_seq_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [PW-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     p_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;
    logic [7:0]        op_count_q;

    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [PW-1:0]     acc_d;
    logic [PW-1:0]     p_d;

    // Magnitudes stay unsigned in WIDTH bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
    always_comb begin
        a_neg = (SIGNED != 0) && bus.a[WIDTH-1];
        b_neg = (SIGNED != 0) && bus.b[WIDTH-1];
        a_mag = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        b_mag = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        p_d   = neg_q ? (~acc_d + PW'(1)) : acc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q    <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q   <= b_mag;
                        acc_q      <= '0;
                        cnt_q      <= CW'(WIDTH);
                        neg_q      <= a_neg ^ b_neg;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    // Last step: the product is written as DONE is entered.
                    if (cnt_q == CW'(1)) begin
                        p_q         <= p_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        op_count_q  <= op_count_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed bench for mult_seq in four configurations
// (WIDTH=8 unsigned/signed, WIDTH=2 unsigned/signed).
module tb_mult_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        iv[4];
    logic        ordy[4];
    logic [31:0] av[4];
    logic [31:0] bv[4];
    logic        ir[4];
    logic        ov[4];
    logic [63:0] pv[4];
    logic [7:0]  oc[4];
    int          exp_oc[4];

    mult_seq_if #(.WIDTH(8)) if0 ();
    mult_seq_if #(.WIDTH(8)) if1 ();
    mult_seq_if #(.WIDTH(2)) if2 ();
    mult_seq_if #(.WIDTH(2)) if3 ();

    mult_seq #(.WIDTH(8), .SIGNED(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    mult_seq #(.WIDTH(8), .SIGNED(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    mult_seq #(.WIDTH(2), .SIGNED(0)) u2 (.clk(clk), .rst(rst), .bus(if2));
    mult_seq #(.WIDTH(2), .SIGNED(1)) u3 (.clk(clk), .rst(rst), .bus(if3));

    assign if0.in_valid = iv[0];  assign if0.out_ready = ordy[0];
    assign if0.a = av[0][7:0];    assign if0.b = bv[0][7:0];
    assign ir[0] = if0.in_ready;  assign ov[0] = if0.out_valid;
    assign pv[0] = {48'd0, if0.p}; assign oc[0] = if0.op_count;

    assign if1.in_valid = iv[1];  assign if1.out_ready = ordy[1];
    assign if1.a = av[1][7:0];    assign if1.b = bv[1][7:0];
    assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid;
    assign pv[1] = {48'd0, if1.p}; assign oc[1] = if1.op_count;

    assign if2.in_valid = iv[2];  assign if2.out_ready = ordy[2];
    assign if2.a = av[2][1:0];    assign if2.b = bv[2][1:0];
    assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid;
    assign pv[2] = {60'd0, if2.p}; assign oc[2] = if2.op_count;

    assign if3.in_valid = iv[3];  assign if3.out_ready = ordy[3];
    assign if3.a = av[3][1:0];    assign if3.b = bv[3][1:0];
    assign ir[3] = if3.in_ready;  assign ov[3] = if3.out_valid;
    assign pv[3] = {60'd0, if3.p}; assign oc[3] = if3.op_count;

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int k, logic [31:0] a, logic [31:0] b, logic [63:0] e);
        vec_t v;
        v.k = k; v.a = a; v.b = b; v.exp = e;
        return v;
    endfunction

    function automatic int wof(int k);
        return (k < 2) ? 8 : 2;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; one full operation with handshake on instance k.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit rdy_in_run);
        int n;
        int lat;
        n = 0;
        while (!ir[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 64'(ir[k]), 64'd1);
        iv[k] = 1'b1; av[k] = a; bv[k] = b; ordy[k] = rdy_in_run;
        @(negedge clk);
        iv[k] = 1'b0; av[k] = $urandom; bv[k] = $urandom;
        lat = 0;
        while (!ov[k] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency k%0d a%0h b%0h", k, a, b), 64'(lat), 64'(wof(k)));
        chk($sformatf("product k%0d a%0h b%0h", k, a, b), pv[k], exp);
        ordy[k] = 1'b1;
        @(negedge clk);
        exp_oc[k] = (exp_oc[k] + 1) & 255;
        chk("post_hs_idle", {62'd0, ov[k], ir[k]}, 64'b01);
        chk("post_hs_count", 64'(oc[k]), 64'(exp_oc[k]));
        chk("post_hs_p_kept", pv[k], exp);
        ordy[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tprev;
        int base;
        int prev_oc;
        int saw_wrap;
        int sa;
        int sb;

        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; av[k] = '0; bv[k] = '0; exp_oc[k] = 0;
        end

        vecs.push_back(mk(0, 13, 11, 64'h008F));
        vecs.push_back(mk(0, 0, 77, 64'h0000));
        vecs.push_back(mk(0, 1, 200, 64'h00C8));
        vecs.push_back(mk(0, 128, 2, 64'h0100));
        vecs.push_back(mk(0, 100, 0, 64'h0000));
        vecs.push_back(mk(0, 255, 1, 64'h00FF));
        vecs.push_back(mk(1, 32'hFD, 32'h05, 64'hFFF1));
        vecs.push_back(mk(1, 32'h80, 32'h80, 64'h4000));
        vecs.push_back(mk(1, 32'h80, 32'h7F, 64'hC080));
        vecs.push_back(mk(1, 32'h00, 32'hFF, 64'h0000));
        vecs.push_back(mk(1, 32'h7F, 32'h7F, 64'h3F01));
        vecs.push_back(mk(1, 32'hFF, 32'hFF, 64'h0001));
        vecs.push_back(mk(1, 32'hFF, 32'h01, 64'hFFFF));
        vecs.push_back(mk(1, 32'h80, 32'h01, 64'hFF80));
        vecs.push_back(mk(1, 32'h05, 32'hF9, 64'hFFDD));

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_in_ready k%0d", k), 64'(ir[k]), 64'd1);
            chk($sformatf("rst_out_valid k%0d", k), 64'(ov[k]), 64'd0);
            chk($sformatf("rst_p k%0d", k), pv[k], 64'd0);
            chk($sformatf("rst_op_count k%0d", k), 64'(oc[k]), 64'd0);
        end
        rst = 1'b0;

        // 255*255, op_count 0 -> 1
        run_op(0, 255, 255, 64'hFE01, 1'b0);

        // Reset three edges into RUN aborts the operation
        iv[0] = 1'b1; av[0] = 255; bv[0] = 255; ordy[0] = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_in_ready", 64'(ir[0]), 64'd0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(ov[0]), 64'd0);
        chk("abort_p", pv[0], 64'd0);
        chk("abort_in_ready", 64'(ir[0]), 64'd1);
        chk("abort_op_count", 64'(oc[0]), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_no_product", 64'(ov[0]), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) exp_oc[k] = 0;

        // Table of directed vectors (first one lands on the edge right after release)
        foreach (vecs[i]) run_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].exp, i[0]);

        // Backpressure: 200*3 held in DONE for five cycles
        iv[0] = 1'b1; av[0] = 200; bv[0] = 3; ordy[0] = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", 64'(n), 64'd8);
        for (int c = 0; c < 5; c++) begin
            iv[0] = 1'b1; av[0] = $urandom; bv[0] = ~bv[0];
            @(negedge clk);
            chk($sformatf("bp_p c%0d", c), pv[0], 64'h0258);
            chk($sformatf("bp_out_valid c%0d", c), 64'(ov[0]), 64'd1);
            chk($sformatf("bp_in_ready c%0d", c), 64'(ir[0]), 64'd0);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(negedge clk);
        exp_oc[0] = (exp_oc[0] + 1) & 255;
        chk("bp_release_idle", {62'd0, ov[0], ir[0]}, 64'b01);
        chk("bp_release_count", 64'(oc[0]), 64'(exp_oc[0]));
        chk("bp_release_p", pv[0], 64'h0258);
        ordy[0] = 1'b0;

        // Exhaustive WIDTH=2, both modes
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                run_op(2, 32'(a), 32'(b), 64'(a * b), 1'b1);
                sa = (a > 1) ? a - 4 : a;
                sb = (b > 1) ? b - 4 : b;
                run_op(3, 32'(a), 32'(b), 64'((sa * sb) & 15), 1'b0);
            end
        end

        // 256 back-to-back operations with in_valid and out_ready held high
        base = exp_oc[0];
        tprev = 0;
        prev_oc = 0;
        saw_wrap = 0;
        iv[0] = 1'b1; av[0] = 3; bv[0] = 5; ordy[0] = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            n = 0;
            while (!ir[0] && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("wrap_wait", 64'(ir[0]), 64'd1);
            chk($sformatf("wrap_count i%0d", i), 64'(oc[0]), 64'((base + i) & 255));
            if (i > 0) begin
                chk($sformatf("wrap_spacing i%0d", i), 64'(cyc - tprev), 64'd10);
                if (prev_oc == 255 && oc[0] == 8'd0) saw_wrap++;
            end
            tprev = cyc;
            prev_oc = int'(oc[0]);
            if (i == 256) iv[0] = 1'b0;
            @(negedge clk);
        end
        chk("wrap_255_to_0", 64'(saw_wrap), 64'd1);
        chk("wrap_last_p", pv[0], 64'd15);
        ordy[0] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter SIGNED, default 0; 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand pair on a/b is valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 out_valid  output  1  product on p is valid.
REQ-010 out_ready  input  1  consumer accepts p.
REQ-011 p  output  2*WIDTH  product.
REQ-012 op_count  output  8  number of completed products, wrapping.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 Accept: an edge with in_valid=1 in IDLE SHALL capture a and b into internal registers, load the step counter with WIDTH, and enter RUN.
REQ-016 After acceptance, a and b SHALL be don't-care; changes to them SHALL NOT affect the result.
REQ-017 in_valid SHALL be ignored in RUN and DONE; no operand is queued.
REQ-018 Each RUN cycle SHALL perform one shift-add step: examine one multiplier bit, LSB first, and conditionally add the shifted multiplicand magnitude into a 2*WIDTH accumulator.
REQ-019 The FSM SHALL enter DONE on the WIDTH-th edge after the accepting edge, so out_valid is visible for the first time WIDTH edges after acceptance; latency is independent of operand values.
REQ-020 SIGNED=0: p SHALL equal a*b, unsigned, exact in 2*WIDTH bits.
REQ-021 SIGNED=1: the multiply SHALL be done on magnitudes, and the result SHALL be negated (two's complement) if the operand signs differ.
REQ-022 SIGNED=1: p SHALL equal the exact signed product in 2*WIDTH bits, including operands equal to -2^(WIDTH-1); the magnitude 2^(WIDTH-1) SHALL be held unsigned in WIDTH bits.
REQ-023 p SHALL hold stable while out_valid=1 and out_ready=0, for an unbounded time.
REQ-024 An edge in DONE with out_ready=1 SHALL return the FSM to IDLE and increment op_count by 1, mod 256 (255 -> 0).
REQ-025 Outside DONE, out_ready SHALL be ignored.
REQ-026 Minimum spacing between acceptances SHALL be WIDTH+2 edges, with out_ready tied high.
REQ-027 p SHALL retain the last product after leaving DONE, until the next product is written at entry to DONE.
REQ-028 An operand of zero SHALL still take the full WIDTH RUN cycles and yield p=0.

Reset
REQ-029 While rst=1, the block SHALL immediately, without waiting for clk, force state=IDLE, in_ready=1, out_valid=0, p=0, op_count=0, and clear the accumulator, counter and operand registers.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation; no product is delivered and op_count is not incremented.
REQ-031 After rst is released, the first rising edge SHALL be able to accept an operand pair.

Verification
REQ-032 Unsigned, WIDTH=8, SIGNED=0: a=255, b=255 accepted -> out_valid rises exactly 8 edges later with p=65025 (0xFE01); op_count goes 0 -> 1 on the handshake.
REQ-033 Signed, WIDTH=8, SIGNED=1: (-3)*5 -> p=0xFFF1; (-128)*(-128) -> p=0x4000; (-128)*127 -> p=0xC080; 0*(-1) -> p=0.
REQ-034 Exhaustive, WIDTH=2: all 16 (a,b) pairs in both modes -> each p matches the reference product. Example: unsigned 3*3=9; signed (-2)*(-2)=4; signed (-1)*1=0xF.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new a/b toggling -> p, out_valid=1 and in_ready=0 stay unchanged; release -> one handshake, IDLE on the next edge.
REQ-036 Reset mid-RUN: assert rst 3 edges after acceptance -> out_valid=0, p=0, in_ready=1 immediately; op_count unchanged at 0; the next operation after release completes correctly.
REQ-037 Counter wrap: 256 back-to-back operations, out_ready=1 -> op_count reads 255 then 0; spacing is exactly WIDTH+2 edges with in_valid held high.
